// File: rtl/robot_pkg.sv
// Shared types and constants for the robot move sequencer.
package robot_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLE   = 3'd1,
        ST_DECIDE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MOVE_FWD = 3'd4,
        ST_MOVE_ROT = 3'd5,
        ST_FAULT    = 3'd6
    } seq_state_e;

    // Fault cause codes
    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_BOXED   = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL = 2'b10;

    // {cmd_front, cmd_rotate} encodings from the decision FSM
    localparam logic [1:0] CMD_FRONT  = 2'b10;
    localparam logic [1:0] CMD_ROTATE = 2'b01;

    // Saturating 16-bit increment for the move counter
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Debounces one raw wall sensor: the clean output only follows the raw
// input after it has disagreed for DEB_CYCLES consecutive cycles.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    // Count disagreement cycles; flip the clean value on the last one
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (raw == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            clean_d = raw;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/robot_move_sequencer.sv
// Sequencer around the wall-following decision FSM: debounces sensors,
// strobes the decision FSM once per move, turns its command into a timed
// motor pulse, counts moves and latches boxed-in / illegal-command faults.
module robot_move_sequencer
    import robot_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned FWD_CYCLES    = 8,
    parameter int unsigned ROT_CYCLES    = 12,
    parameter int unsigned MAX_ROTS      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        head_raw,
    input  logic        left_raw,
    input  logic        cmd_front,
    input  logic        cmd_rotate,
    output logic        head,
    output logic        left,
    output logic        step,
    output logic        motor_fwd,
    output logic        motor_rot,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [15:0] move_count
);

    // One down-counter times both settle and move phases, sized to the longest
    localparam int unsigned CNT_MAX0 = (SETTLE_CYCLES > FWD_CYCLES) ? SETTLE_CYCLES : FWD_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > ROT_CYCLES) ? CNT_MAX0 : ROT_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned ROT_W    = $clog2(MAX_ROTS + 1);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FWD_LD    = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ROT_LD    = CNT_W'(ROT_CYCLES - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROT_W-1:0] rot_q, rot_d, rot_inc;
    logic [15:0]      mc_q, mc_d;
    logic [1:0]       fc_q, fc_d;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_head (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (head_raw),
        .clean (head)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (left_raw),
        .clean (left)
    );

    // State and datapath registers; reset forces IDLE so motors drop at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rot_q   <= '0;
            mc_q    <= '0;
            fc_q    <= FLT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            mc_q    <= mc_d;
            fc_q    <= fc_d;
        end
    end

    assign rot_inc = rot_q + ROT_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        mc_d    = mc_q;
        fc_d    = fc_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_SAMPLE: begin
                if (!run)               state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_DECIDE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DECIDE: state_d = ST_EXEC;
            ST_EXEC: begin
                case ({cmd_front, cmd_rotate})
                    CMD_FRONT: begin
                        state_d = ST_MOVE_FWD;
                        cnt_d   = FWD_LD;
                        rot_d   = '0;
                    end
                    CMD_ROTATE: begin
                        rot_d = rot_inc;
                        if (rot_inc == ROT_W'(MAX_ROTS)) begin
                            state_d = ST_FAULT;
                            fc_d    = FLT_BOXED;
                        end else begin
                            state_d = ST_MOVE_ROT;
                            cnt_d   = ROT_LD;
                        end
                    end
                    default: begin
                        state_d = ST_FAULT;
                        fc_d    = FLT_ILLEGAL;
                    end
                endcase
            end
            ST_MOVE_FWD, ST_MOVE_ROT: begin
                // run is deliberately ignored here; moves always finish
                if (cnt_q == '0) begin
                    mc_d    = sat_inc16(mc_q);
                    state_d = ST_SAMPLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FAULT: begin
                // Rotation count is cleared so a new run starts fresh
                if (!run) begin
                    state_d = ST_IDLE;
                    fc_d    = FLT_NONE;
                    rot_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state
    always_comb begin
        step      = 1'b0;
        motor_fwd = 1'b0;
        motor_rot = 1'b0;
        busy      = 1'b1;
        fault     = 1'b0;
        case (state_q)
            ST_IDLE:     busy      = 1'b0;
            ST_DECIDE:   step      = 1'b1;
            ST_MOVE_FWD: motor_fwd = 1'b1;
            ST_MOVE_ROT: motor_rot = 1'b1;
            ST_FAULT: begin
                busy  = 1'b0;
                fault = 1'b1;
            end
            default: ;
        endcase
    end

    assign fault_code = fc_q;
    assign move_count = mc_q;

endmodule

// File: tb/tb_robot_move_sequencer.sv
// Directed self-checking bench for robot_move_sequencer (default parameters).
module tb_robot_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, head_raw, left_raw, cmd_front, cmd_rotate;
    logic        head, left, step, motor_fwd, motor_rot, busy, fault;
    logic [1:0]  fault_code;
    logic [15:0] move_count;

    int checks   = 0;
    int failures = 0;

    robot_move_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .head_raw   (head_raw),
        .left_raw   (left_raw),
        .cmd_front  (cmd_front),
        .cmd_rotate (cmd_rotate),
        .head       (head),
        .left       (left),
        .step       (step),
        .motor_fwd  (motor_fwd),
        .motor_rot  (motor_rot),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; head_raw = 1'b0; left_raw = 1'b0;
        cmd_front = 1'b0; cmd_rotate = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; head_raw = 1'b0; left_raw = 1'b0;
        cmd_front = 1'b0; cmd_rotate = 1'b0;
        #12;
        checks++;
        if ({head, left, step, motor_fwd, motor_rot, busy, fault, fault_code, move_count} !== 25'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {head, left, step, motor_fwd, motor_rot, busy, fault, fault_code, move_count});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
    endtask

    task automatic test_forward();
        int steps[$];
        int fwd_first = 0, fwd_cnt = 0, rot_cnt = 0;
        logic [15:0] mc42 = '0, mc43 = '0;
        do_reset();
        {cmd_front, cmd_rotate} = 2'b10;
        run = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (step) steps.push_back(i);
            if (motor_fwd && i < 19) begin fwd_cnt++; if (fwd_first == 0) fwd_first = i; end
            if (motor_rot) rot_cnt++;
            if (i == 42) mc42 = move_count;
            if (i == 43) mc43 = move_count;
        end
        checks++;
        if (steps.size() != 3 || steps[0] != 5 || steps[1] != 19 || steps[2] != 33) begin
            failures++;
            $display("FAIL fwd_step_times n=%0d first=%0d want 5,19,33", steps.size(),
                     steps.size() > 0 ? steps[0] : -1);
        end
        checks++;
        if (fwd_first != 7) begin failures++; $display("FAIL fwd_motor_start got=%0d want=7", fwd_first); end
        checks++;
        if (fwd_cnt != 8) begin failures++; $display("FAIL fwd_pulse_len got=%0d want=8", fwd_cnt); end
        checks++;
        if (rot_cnt != 0) begin failures++; $display("FAIL fwd_no_rot got=%0d want=0", rot_cnt); end
        checks++;
        if (mc42 !== 16'd2 || mc43 !== 16'd3) begin
            failures++;
            $display("FAIL fwd_move_count got=%0d,%0d want=2,3", mc42, mc43);
        end
        run = 1'b0;
    endtask

    task automatic test_rotate_boxed();
        int rot_cnt = 0, pulses = 0, n = 0;
        logic prev = 1'b0;
        do_reset();
        {cmd_front, cmd_rotate} = 2'b01;
        run = 1'b1;
        while (!fault && n < 300) begin
            @(negedge clk);
            n++;
            if (motor_rot) rot_cnt++;
            if (motor_rot && !prev) pulses++;
            prev = motor_rot;
        end
        checks++;
        if (fault !== 1'b1) begin failures++; $display("FAIL boxed_timeout fault=%b want=1", fault); end
        checks++;
        if (pulses != 3 || rot_cnt != 36) begin
            failures++;
            $display("FAIL boxed_pulses got=%0d/%0d want=3/36", pulses, rot_cnt);
        end
        checks++;
        if (fault_code !== 2'b01 || motor_rot !== 1'b0 || motor_fwd !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL boxed_state code=%b rot=%b fwd=%b busy=%b want 01,0,0,0",
                     fault_code, motor_rot, motor_fwd, busy);
        end
        checks++;
        if (move_count !== 16'd3) begin failures++; $display("FAIL boxed_count got=%0d want=3", move_count); end
        repeat (3) @(negedge clk);
        checks++;
        if (fault !== 1'b1 || fault_code !== 2'b01) begin
            failures++;
            $display("FAIL boxed_latched fault=%b code=%b want 1,01", fault, fault_code);
        end
        run = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL boxed_exit fault=%b code=%b busy=%b want 0,00,0", fault, fault_code, busy);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] pats [2];
        pats[0] = 2'b11;
        pats[1] = 2'b00;
        for (int p = 0; p < 2; p++) begin
            int first_fault = 0, motors = 0;
            do_reset();
            {cmd_front, cmd_rotate} = pats[p];
            run = 1'b1;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (fault && first_fault == 0) first_fault = i;
                if (motor_fwd || motor_rot) motors++;
            end
            checks++;
            if (first_fault != 7 || fault_code !== 2'b10 || motors != 0) begin
                failures++;
                $display("FAIL illegal_%b at=%0d code=%b motors=%0d want 7,10,0",
                         pats[p], first_fault, fault_code, motors);
            end
            run = 1'b0;
        end
    endtask

    task automatic test_debounce();
        int early_hi = 0;
        logic h3, h4;
        do_reset();
        // 3-cycle glitch must be rejected
        head_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 3) head_raw = 1'b0;
            if (head) early_hi++;
        end
        checks++;
        if (early_hi != 0) begin failures++; $display("FAIL deb_glitch3 head_hi=%0d want=0", early_hi); end
        // 4-cycle pulse passes on the 4th cycle
        head_raw = 1'b1;
        left_raw = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        h3 = head;
        @(negedge clk);
        h4 = head;
        head_raw = 1'b0;
        checks++;
        if (h3 !== 1'b0 || h4 !== 1'b1) begin
            failures++;
            $display("FAIL deb_glitch4 head@3=%b head@4=%b want 0,1", h3, h4);
        end
        checks++;
        if (left !== 1'b1) begin failures++; $display("FAIL deb_left got=%b want=1", left); end
        left_raw = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (head !== 1'b0 || left !== 1'b0) begin
            failures++;
            $display("FAIL deb_release head=%b left=%b want 0,0", head, left);
        end
    endtask

    task automatic test_run_drop_and_reset();
        int n = 0, rot_cnt = 0;
        do_reset();
        {cmd_front, cmd_rotate} = 2'b01;
        run = 1'b1;
        while (!motor_rot && n < 50) begin @(negedge clk); n++; end
        rot_cnt = motor_rot ? 1 : 0;
        repeat (2) begin @(negedge clk); if (motor_rot) rot_cnt++; end
        run = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
            if (motor_rot) rot_cnt++;
        end
        checks++;
        if (rot_cnt != 12) begin failures++; $display("FAIL drop_pulse_len got=%0d want=12", rot_cnt); end
        checks++;
        if (busy !== 1'b0 || move_count !== 16'd1) begin
            failures++;
            $display("FAIL drop_idle busy=%b count=%0d want 0,1", busy, move_count);
        end
        // Reset in the middle of a rotation
        run = 1'b1;
        n = 0;
        while (!motor_rot && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({step, motor_fwd, motor_rot, busy, fault, fault_code, move_count} !== 23'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0",
                     {step, motor_fwd, motor_rot, busy, fault, fault_code, move_count});
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [15:0] mc14 = '0, mc15 = '0;
        do_reset();
        force dut.mc_q = 16'hFFFE;
        @(negedge clk);
        release dut.mc_q;
        @(negedge clk);
        {cmd_front, cmd_rotate} = 2'b10;
        run = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (i == 14) mc14 = move_count;
            if (i == 15) mc15 = move_count;
        end
        checks++;
        if (mc14 !== 16'hFFFE || mc15 !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_first got=%h,%h want=fffe,ffff", mc14, mc15);
        end
        checks++;
        if (move_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h want=ffff", move_count);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_rotate_boxed();
        test_illegal();
        test_debounce();
        test_run_drop_and_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/robot_move_sequencer.md
# robot_move_sequencer

Sequencer wrapped around the wall-following decision FSM. It debounces the raw head and left wall sensors and advances the decision FSM one step at a time through a step strobe. Each resulting front or rotate command is then executed as a timed motor pulse. It also counts completed moves and raises a latched fault when the robot is boxed in or the decision FSM issues an illegal command.

## Interface
- DEB_CYCLES, 4: consecutive cycles a raw sensor must differ from its debounced value before the debounced value flips (≥1).
- SETTLE_CYCLES, 4: cycles spent in SAMPLE before each decision (≥1).
- FWD_CYCLES, 8: cycles motor_fwd is held per forward move (≥1).
- ROT_CYCLES, 12: cycles motor_rot is held per rotation, i.e. one 90° turn (≥1).
- MAX_ROTS, 4: consecutive rotations that trigger the boxed-in fault (≥2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level enable; 1 = keep moving.
- head_raw  in  1  raw front wall sensor.
- left_raw  in  1  raw left wall sensor.
- cmd_front  in  1  front command from the decision FSM.
- cmd_rotate  in  1  rotate command from the decision FSM.
- head  out  1  debounced head; drives the decision FSM.
- left  out  1  debounced left; drives the decision FSM.
- step  out  1  one-cycle clock-enable strobe to the decision FSM.
- motor_fwd  out  1  forward motor drive.
- motor_rot  out  1  rotate motor drive.
- busy  out  1  high in every state except IDLE and FAULT.
- fault  out  1  latched fault indicator.
- fault_code  out  2  fault cause: 00 none, 01 boxed in, 10 illegal command.
- move_count  out  16  completed moves, saturating.

## Operation
- **Debounce**
  - Each sensor has its own counter and runs continuously, independent of FSM state.
  - While raw ≠ debounced, the counter increments; at DEB_CYCLES the debounced value takes the raw value and the counter clears.
  - Any cycle with raw = debounced clears the counter.
- **FSM states:** IDLE, SAMPLE, DECIDE, EXEC, MOVE_FWD, MOVE_ROT, FAULT.
- **IDLE:** go to SAMPLE when run=1.
- **SAMPLE:** wait exactly SETTLE_CYCLES cycles, then go to DECIDE. If run=0, go to IDLE instead.
- **DECIDE:** assert step for exactly this one cycle; the decision FSM updates on this edge. Next state is EXEC.
- **EXEC:** decode {cmd_front, cmd_rotate}.
  - 10: go to MOVE_FWD and clear the rotation counter.
  - 01: increment the rotation counter.
    - If the new count equals MAX_ROTS, go to FAULT with code 01.
    - Otherwise go to MOVE_ROT.
  - 00 or 11: go to FAULT with code 10.
- **MOVE_FWD / MOVE_ROT**
  - Drive the matching motor for exactly FWD_CYCLES / ROT_CYCLES cycles.
  - On the last cycle, increment move_count (saturating at 16'hFFFF), then go to SAMPLE.
  - run=0 does not abort a move; it is checked in SAMPLE.
- **FAULT**
  - Motors off, step=0, fault=1, fault_code held.
  - Exit to IDLE only when run=0; fault and fault_code clear on that exit.
- **Motor rule:** motor_fwd and motor_rot are never high together.
- **Reset values:** state IDLE; all outputs 0; head=0, left=0; debounce counters, rotation counter and move_count all 0.
- **Reset mid-move:** motors drop asynchronously with rst_n.

## Timing
- All outputs are registered or decoded directly from registered state; no combinational path from inputs to outputs.
- run rising in IDLE:
  - SAMPLE is entered at the next edge.
  - step is high SETTLE_CYCLES+1 cycles after run is first sampled high.
  - Motor drive starts 2 cycles after step.
- Cycles per move, SAMPLE entry to next SAMPLE entry:
  - forward: SETTLE_CYCLES+2+FWD_CYCLES;
  - rotation: SETTLE_CYCLES+2+ROT_CYCLES.
- A raw edge reaches head/left DEB_CYCLES cycles after the raw change, if it stays stable.
- The debounced sensors may change while a move is running; the decision FSM only sees them at the step edge.
- cmd_front/cmd_rotate are sampled only in EXEC, one cycle after step.

## Structure
- Package robot_pkg holds:
  - the sequencer state enum;
  - fault_code constants FLT_NONE, FLT_BOXED, FLT_ILLEGAL;
  - the 2-bit command encodings CMD_FRONT=2'b10 and CMD_ROTATE=2'b01.
- Sub-module sensor_debounce (parameter DEB_CYCLES; ports clk, rst_n, raw, clean) is instantiated twice.
- One shared down-counter is used for settle and move timing, sized to the largest parameter.

## Test plan
- Defaults, raw sensors 0, stub FSM returns 10 forever, run=1 → step every 14 cycles; motor_fwd 8 cycles per move; move_count=3 after 42 cycles of motion.
- Stub returns 01 four times in a row → three 12-cycle motor_rot pulses, then fault=1, fault_code=01 and motors 0. Drop run → IDLE with fault=0.
- Stub returns 11 at EXEC → FAULT with code 10 and no motor pulse.
- head_raw glitch of 3 cycles → head stays 0. Glitch of 4 cycles → head=1 on the 4th cycle after the edge.
- Drop run mid-MOVE_ROT → pulse completes its full 12 cycles, then IDLE with busy=0. Assert rst_n=0 mid-move → all outputs 0 immediately.
- Force move_count to 16'hFFFE, run 3 moves → count holds at 16'hFFFF.
